// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment debug display: mode
// encoding, hex-to-segment lookup and output reset values.
package display_pkg;

    typedef enum logic [1:0] {
        SHOW_V0 = 2'b01,
        SHOW_V1 = 2'b10,
        SHOW_PC = 2'b11
    } mode_e;

    localparam logic [7:0] AN_RESET  = 8'hFF;
    localparam logic [6:0] SEG_RESET = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; element [0] is the code for nibble 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seven_seg_debug_display_if.sv
// Bundle of processor debug values, button/freeze controls and display
// drive lines; slave is the display side, master is whoever drives it.
interface seven_seg_debug_display_if;

    logic [31:0] PCValue;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        ModeBtn;
    logic        Freeze;
    logic [7:0]  An;
    logic [6:0]  Seg;
    logic        Dp;
    logic [1:0]  ModeLed;

    modport master (
        output PCValue, v0, v1, ModeBtn, Freeze,
        input  An, Seg, Dp, ModeLed
    );

    modport slave (
        input  PCValue, v0, v1, ModeBtn, Freeze,
        output An, Seg, Dp, ModeLed
    );

endinterface

// File: rtl/button_debouncer.sv
// Synchronizes a raw push-button and accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES cycles; emits a one-cycle press on 0->1.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The count only survives while the synchronized input disagrees with
    // the accepted level; any agreeing cycle starts it over.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/seven_seg_debug_display.sv
// Eight-digit multiplexed hex display of the processor's v0, v1 and PC, with
// a button-selected mode and a freeze input that holds a snapshot.
module seven_seg_debug_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic Clk,
    input  logic Rst,
    seven_seg_debug_display_if.slave io
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

    logic [31:0]   cap_v0_q, cap_v0_d;
    logic [31:0]   cap_v1_q, cap_v1_d;
    logic [31:0]   cap_pc_q, cap_pc_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [2:0]    idx_q, idx_d;
    mode_e         mode_q, mode_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [31:0]   shown;
    logic          press;
    logic          btn_level_unused;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debouncer (
        .Clk    (Clk),
        .Rst    (Rst),
        .btn_raw(io.ModeBtn),
        .level  (btn_level_unused),
        .press  (press)
    );

    always_comb begin
        mode_d = mode_q;
        if (press) begin
            case (mode_q)
                SHOW_V0: mode_d = SHOW_V1;
                SHOW_V1: mode_d = SHOW_PC;
                SHOW_PC: mode_d = SHOW_V0;
                default: mode_d = SHOW_V0;
            endcase
        end
    end

    // The output register reads the digit index and capture contents from
    // before this edge, giving the two-cycle input-to-display path.
    always_comb begin
        cap_v0_d  = cap_v0_q;
        cap_v1_d  = cap_v1_q;
        cap_pc_d  = cap_pc_q;
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (!io.Freeze) begin
            cap_v0_d = io.v0;
            cap_v1_d = io.v1;
            cap_pc_d = io.PCValue;
        end
        if (refresh_q == REFRESH_MAX) begin
            refresh_d = '0;
            idx_d     = idx_q + 3'd1;
        end
        case (mode_q)
            SHOW_V1: shown = cap_v1_q;
            SHOW_PC: shown = cap_pc_q;
            default: shown = cap_v0_q;
        endcase
        an_d  = ~(8'b1 << idx_q);
        seg_d = hex_to_seg(shown[{idx_q, 2'b00} +: 4]);
        dp_d  = ~((idx_q == 3'd0) & io.Freeze);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cap_v0_q  <= '0;
            cap_v1_q  <= '0;
            cap_pc_q  <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            mode_q    <= SHOW_V0;
            an_q      <= AN_RESET;
            seg_q     <= SEG_RESET;
            dp_q      <= 1'b1;
        end else begin
            cap_v0_q  <= cap_v0_d;
            cap_v1_q  <= cap_v1_d;
            cap_pc_q  <= cap_pc_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign io.An      = an_q;
    assign io.Seg     = seg_q;
    assign io.Dp      = dp_q;
    assign io.ModeLed = mode_q;

endmodule

// File: tb/tb_seven_seg_debug_display.sv
// Directed scoreboard bench for seven_seg_debug_display with a short refresh
// divider and debounce window so whole frames and presses fit in a few hundred cycles.
module tb_seven_seg_debug_display;

    localparam int REFRESH_DIV     = 4;
    localparam int DEBOUNCE_CYCLES = 8;

    logic Clk = 1'b0;
    logic Rst;

    seven_seg_debug_display_if io();

    seven_seg_debug_display #(
        .REFRESH_DIV    (REFRESH_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .io (io)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      tag;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] led;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [1:0]  modeTb   = 2'b01;
    bit          freezeTb = 1'b0;
    logic [31:0] pcTb, v0Tb, v1Tb;
    int          wrapStart;

    function automatic logic [6:0] hexTb(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge Clk);
            cyc++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] a,
                                 input logic [31:0] b, input logic frz);
        io.PCValue = pc;
        io.v0      = a;
        io.v1      = b;
        io.Freeze  = frz;
        pcTb       = pc;
        v0Tb       = a;
        v1Tb       = b;
        freezeTb   = frz;
    endtask

    task automatic checkOutput();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (io.An === e.an) else begin
            failures++;
            $error("FAIL %s An got=%h want=%h", e.tag, io.An, e.an);
        end
        checks++;
        assert (io.Seg === e.seg) else begin
            failures++;
            $error("FAIL %s Seg got=%b want=%b", e.tag, io.Seg, e.seg);
        end
        checks++;
        assert (io.Dp === e.dp) else begin
            failures++;
            $error("FAIL %s Dp got=%b want=%b", e.tag, io.Dp, e.dp);
        end
        checks++;
        assert (io.ModeLed === e.led) else begin
            failures++;
            $error("FAIL %s ModeLed got=%b want=%b", e.tag, io.ModeLed, e.led);
        end
    endtask

    task automatic expectOut(input string tag, input logic [7:0] an, input logic [6:0] seg,
                             input logic dp, input logic [1:0] led);
        exp_t e;
        e.tag = tag;
        e.an  = an;
        e.seg = seg;
        e.dp  = dp;
        e.led = led;
        sb.push_back(e);
    endtask

    // Digit shown after posedge number cyc (counted from reset release).
    task automatic expectDigit(input string tag, input logic [31:0] value);
        int          d;
        logic [31:0] v;
        d = ((cyc - 1) / REFRESH_DIV) % 8;
        v = value >> (4 * d);
        expectOut(tag, ~(8'(1) << d), hexTb(v[3:0]),
                  (d == 0 && freezeTb) ? 1'b0 : 1'b1, modeTb);
        checkOutput();
    endtask

    task automatic waitDigit(input int d, input int off);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cyc >= 1 && ((cyc - 1) / REFRESH_DIV) % 8 == d && (cyc - 1) % REFRESH_DIV == off)
                found = 1'b1;
            else
                step(1);
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL waitDigit got=timeout want=digit%0d", d);
        end
    endtask

    task automatic pressButton(input int hold);
        io.ModeBtn = 1'b1;
        step(hold);
        io.ModeBtn = 1'b0;
        step(14);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst        = 1'b1;
        io.ModeBtn = 1'b0;
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);
        step(2);
        expectOut("reset", 8'hFF, 7'h7F, 1'b1, 2'b01);
        checkOutput();

        $display("[TB] scan v0=89ABCDEF");
        applyStimulus(32'h0, 32'h89ABCDEF, 32'h0, 1'b0);
        Rst = 1'b0;
        cyc = 0;
        step(1);
        expectOut("first_clock", 8'hFE, 7'b1000000, 1'b1, 2'b01);
        checkOutput();
        for (int k = 0; k < 33; k++) begin
            step(1);
            expectDigit("scan", v0Tb);
        end

        $display("[TB] mode cycling");
        applyStimulus(32'h00400010, 32'h89ABCDEF, 32'h13579BDF, 1'b0);
        pressButton(20);
        modeTb = 2'b10;
        expectDigit("mode_v1", v1Tb);
        pressButton(20);
        modeTb = 2'b11;
        waitDigit(1, 1);
        expectDigit("pc_idx1", pcTb);
        pressButton(20);
        modeTb = 2'b01;
        expectDigit("mode_v0", v0Tb);

        $display("[TB] bounce");
        for (int i = 0; i < 10; i++) begin
            io.ModeBtn = (i % 2 == 0);
            step(3);
        end
        expectDigit("bounce_none", v0Tb);
        io.ModeBtn = 1'b1;
        step(12);
        io.ModeBtn = 1'b0;
        step(14);
        modeTb = 2'b10;
        expectDigit("bounce_one", v1Tb);

        $display("[TB] reset mid-scan");
        step(5);
        Rst = 1'b1;
        #1;
        expectOut("rst_async", 8'hFF, 7'h7F, 1'b1, 2'b01);
        checkOutput();
        step(1);
        Rst    = 1'b0;
        cyc    = 0;
        modeTb = 2'b01;
        step(1);
        expectOut("rst_release", 8'hFE, 7'b1000000, 1'b1, 2'b01);
        checkOutput();
        step(1);
        expectDigit("rst_capture", v0Tb);

        $display("[TB] freeze");
        applyStimulus(32'h00400010, 32'h0000000A, 32'h000000F0, 1'b0);
        step(2);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b1);
        step(1);
        waitDigit(0, 1);
        expectDigit("frz_idx0", 32'h0000000A);
        waitDigit(1, 0);
        expectDigit("frz_idx1", 32'h0000000A);
        pressButton(20);
        modeTb = 2'b10;
        waitDigit(1, 2);
        expectDigit("frz_press_v1", 32'h000000F0);
        pressButton(20);
        pressButton(20);
        modeTb = 2'b01;
        waitDigit(0, 0);
        expectDigit("frz_still", 32'h0000000A);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);
        step(2);
        expectDigit("unfreeze", 32'h0);

        $display("[TB] press at digit wrap");
        applyStimulus(32'h0, 32'h76543210, 32'hFEDCBA98, 1'b0);
        step(2);
        for (int i = 0; i < 4 && (cyc % REFRESH_DIV) != 1; i++)
            step(1);
        wrapStart  = cyc;
        io.ModeBtn = 1'b1;
        step(11);
        checks++;
        assert (cyc - wrapStart == 11 && (cyc % REFRESH_DIV) == 0) else begin
            failures++;
            $error("FAIL wrap_align got=%0d want=0", cyc % REFRESH_DIV);
        end
        modeTb = 2'b10;
        expectDigit("wrap_edge", v0Tb);
        step(1);
        expectDigit("wrap_after", v1Tb);
        step(4);
        expectDigit("wrap_next", v1Tb);
        io.ModeBtn = 1'b0;
        step(14);
        expectDigit("wrap_settle", v1Tb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
